hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline interlock and sequencing controller placed beside the decode stage of the 5-stage CPU.
- Tracks in-flight register writes in a destination scoreboard covering EX, MEM and WB.
- Stalls fetch/decode on read-after-write hazards, because the datapath has no forwarding.
- Squashes wrong-path instructions on EX redirects and sequences a clean drain-and-stop on a HALT instruction.

Parameters:
- DEPTH, 3: number of tracked stages after ID (EX, MEM, WB).
- WB_BYPASS, 0: 1 = register file write-before-read, so the last stage (WB) is excluded from the hazard compare.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  3  source register s (Instr[10:8])
- id_rs_used  in  1  instruction reads rs
- id_rt  in  3  source register t (Instr[7:5])
- id_rt_used  in  1  instruction reads rt
- id_wr_en  in  1  instruction writes a register (RegWriteEn)
- id_wr_dst  in  3  destination register (writeregsel)
- id_halt  in  1  instruction is HALT
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- idex_bubble  out  1  load NOP control word into ID/EX
- ifid_flush  out  1  clear IF/ID to NOP
- halted  out  1  core stopped; dump may begin
- state  out  2  00 RUN, 01 DRAIN, 10 HALTED

Behaviour:
- Scoreboard: DEPTH-entry shift register, {valid, dst}; entry 0 = EX, entry DEPTH-1 = WB. It shifts every cycle the core is not HALTED.
  - Entry 0 loads {id_valid & id_wr_en & ~stall & ~ex_redirect & state==RUN, id_wr_dst}.
  - When a bubble is inserted, entry 0 loads valid=0.
- Hazard: raw_hit is 1 if any valid compared entry has dst==id_rs with id_rs_used, or dst==id_rt with id_rt_used.
  - Compared entries are 0..DEPTH-1, or 0..DEPTH-2 when WB_BYPASS=1.
  - Gated by id_valid. R0 is an ordinary register and is not exempt.
- stall = raw_hit & ~ex_redirect & state==RUN. While stall is high: pc_stall=1, ifid_stall=1, idex_bubble=1, ifid_flush=0.
- Redirect has priority over stall. With ex_redirect=1 in RUN or DRAIN: ifid_flush=1, idex_bubble=1, pc_stall=0, ifid_stall=0.
  - The ID instruction is squashed and not entered into the scoreboard.
  - Scoreboard entry 0 (the EX branch itself) is kept.
- All handshake outputs are combinational from state, scoreboard and inputs; scoreboard and FSM update on the clock edge.
- FSM:
  - RUN -> DRAIN: id_valid & id_halt & ~stall & ~ex_redirect.
    - That cycle the HALT advances normally; drain_cnt is loaded with DEPTH.
  - DRAIN: pc_stall=1, ifid_stall=1, idex_bubble=1. drain_cnt decrements each cycle.
    - ex_redirect in DRAIN (an older branch took) cancels the halt: -> RUN, drain_cnt cleared, flush outputs as above.
    - drain_cnt reaching 1 with no redirect -> HALTED.
  - HALTED: absorbing until reset. halted=1, pc_stall=1, ifid_stall=1, idex_bubble=1. Scoreboard frozen; inputs ignored.
- Reset (rst=0, asynchronous):
  - state=RUN, drain_cnt=0, all scoreboard valid=0.
  - Outputs become pc_stall=0, ifid_stall=0, idex_bubble=0, ifid_flush=0, halted=0 immediately, independent of clk.
  - Reset mid-stall or mid-drain discards all pending state.
- Simultaneous cases:
  - HALT in ID with raw_hit: stall first; enter DRAIN only after the hazard clears.
  - HALT in ID with ex_redirect: the HALT is squashed; stay in RUN.
  - Writer in WB while a reader is in ID with WB_BYPASS=0: stall one more cycle.

Test Plan:
- Reset with id_valid=1, id_rs=3, id_rs_used=1 -> all outputs 0, state=00, no stall (empty scoreboard).
- ADD writing r3, then a reader of r3 in the next cycle (WB_BYPASS=0) -> pc_stall/ifid_stall/idex_bubble high for exactly 3 cycles, then released. With WB_BYPASS=1 -> exactly 2 cycles.
- Reader of r3 stalled on r3 while ex_redirect=1 in the same cycle -> ifid_flush=1, idex_bubble=1, pc_stall=0. Next cycle: no stall, entry 0 invalid.
- HALT with no hazards -> state 01 for 3 cycles (front end held), then state=10 and halted=1 permanently. Later id_valid/ex_redirect activity -> no change.
- HALT enters DRAIN, ex_redirect pulses on the 2nd DRAIN cycle -> state returns to 00, ifid_flush=1 that cycle, halted stays 0.
- Assert rst=0 asynchronously mid-DRAIN (between clock edges) -> outputs clear immediately; after release, the first reader of any register does not stall.

Source files
------------

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - decode-stage interlock: RAW scoreboard stall, redirect squash, halt drain
module hazard_sched #(
    parameter int DEPTH     = 3,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_rs,
    input  logic       id_rs_used,
    input  logic [2:0] id_rt,
    input  logic       id_rt_used,
    input  logic       id_wr_en,
    input  logic [2:0] id_wr_dst,
    input  logic       id_halt,
    input  logic       ex_redirect,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       halted,
    output logic [1:0] state
);

    localparam int NCMP = WB_BYPASS ? DEPTH - 1 : DEPTH;
    localparam int CW   = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           drain_cnt_q, drain_cnt_d;
    logic [DEPTH-1:0]        sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0][2:0]   sb_dst_q, sb_dst_d;

    logic raw_hit;
    logic in_run;
    logic stall;
    logic pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c, halted_c;

    // Entry 0 is EX; the WB entry is skipped when the register file writes before it reads.
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NCMP; i++) begin
            if (sb_valid_q[i] &&
                ((id_rs_used && (sb_dst_q[i] == id_rs)) ||
                 (id_rt_used && (sb_dst_q[i] == id_rt)))) begin
                raw_hit = 1'b1;
            end
        end
        raw_hit = raw_hit & id_valid;
    end

    assign in_run = (state_q == ST_RUN);
    assign stall  = raw_hit & ~ex_redirect & in_run;

    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_dst_d   = sb_dst_q;
        if (state_q != ST_HALTED) begin
            for (int i = 1; i < DEPTH; i++) begin
                sb_valid_d[i] = sb_valid_q[i-1];
                sb_dst_d[i]   = sb_dst_q[i-1];
            end
            sb_valid_d[0] = id_valid & id_wr_en & ~stall & ~ex_redirect & in_run;
            sb_dst_d[0]   = id_wr_dst;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        idex_bubble_c = 1'b0;
        ifid_flush_c  = 1'b0;
        halted_c      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (raw_hit) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (id_valid && id_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = CW'(DEPTH);
                end
            end
            ST_DRAIN: begin
                if (ex_redirect) begin
                    // An older branch resolved taken, so the HALT was on the wrong path.
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    state_d       = ST_RUN;
                    drain_cnt_d   = '0;
                end else begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    drain_cnt_d   = drain_cnt_q - CW'(1);
                    if (drain_cnt_q == CW'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                pc_stall_c    = 1'b1;
                ifid_stall_c  = 1'b1;
                idex_bubble_c = 1'b1;
                halted_c      = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            sb_valid_q  <= '0;
            sb_dst_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            sb_valid_q  <= sb_valid_d;
            sb_dst_q    <= sb_dst_d;
        end
    end

    // Gating with rst keeps the handshake quiet during reset even if ex_redirect is asserted.
    assign pc_stall    = rst & pc_stall_c;
    assign ifid_stall  = rst & ifid_stall_c;
    assign idex_bubble = rst & idex_bubble_c;
    assign ifid_flush  = rst & ifid_flush_c;
    assign halted      = rst & halted_c;
    assign state       = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - bench for hazard_sched, WB_BYPASS=0 and WB_BYPASS=1 side by side
module tb_hazard_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, ex_redirect;
    logic [2:0] id_rs, id_rt, id_wr_dst;

    logic       pc_stall_a, ifid_stall_a, idex_bubble_a, ifid_flush_a, halted_a;
    logic [1:0] state_a;
    logic       pc_stall_b, ifid_stall_b, idex_bubble_b, ifid_flush_b, halted_b;
    logic [1:0] state_b;

    always #5 clk = ~clk;

    hazard_sched #(.DEPTH(3), .WB_BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .pc_stall(pc_stall_a),
        .ifid_stall(ifid_stall_a), .idex_bubble(idex_bubble_a), .ifid_flush(ifid_flush_a),
        .halted(halted_a), .state(state_a)
    );

    hazard_sched #(.DEPTH(3), .WB_BYPASS(1'b1)) u_wb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .pc_stall(pc_stall_b),
        .ifid_stall(ifid_stall_b), .idex_bubble(idex_bubble_b), .ifid_flush(ifid_flush_b),
        .halted(halted_b), .state(state_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference: per configuration, a pool of in-flight writes tagged with their age in stages.
    int         m_mode [2];
    int         m_left [2];
    bit         s_live [2][8];
    int         s_age  [2][8];
    logic [2:0] s_dst  [2][8];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int c);
        int ncmp = (c == 1) ? 2 : 3;
        bit h = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s_live[c][k] && s_age[c][k] < ncmp &&
                ((id_rs_used && s_dst[c][k] == id_rs) || (id_rt_used && s_dst[c][k] == id_rt)))
                h = 1'b1;
        end
        return h & id_valid;
    endfunction

    // {halted, ifid_flush, idex_bubble, ifid_stall, pc_stall, state[1:0]}
    function automatic logic [7:0] m_out(input int c);
        logic pc = 0, fs = 0, bb = 0, fl = 0, hl = 0;
        if (m_mode[c] == 0) begin
            if (ex_redirect) begin fl = 1; bb = 1; end
            else if (m_hit(c)) begin pc = 1; fs = 1; bb = 1; end
        end else if (m_mode[c] == 1) begin
            if (ex_redirect) begin fl = 1; bb = 1; end
            else begin pc = 1; fs = 1; bb = 1; end
        end else begin
            pc = 1; fs = 1; bb = 1; hl = 1;
        end
        return {1'b0, hl, fl, bb, fs, pc, 2'(m_mode[c])};
    endfunction

    task automatic m_advance(input int c);
        bit st = m_hit(c) && !ex_redirect && m_mode[c] == 0;
        bit placed = 1'b0;
        if (m_mode[c] == 2) return;
        for (int k = 0; k < 8; k++) begin
            if (s_live[c][k]) begin
                s_age[c][k]++;
                if (s_age[c][k] >= 3) s_live[c][k] = 1'b0;
            end
        end
        if (m_mode[c] == 0 && id_valid && id_wr_en && !st && !ex_redirect) begin
            for (int k = 0; k < 8; k++) begin
                if (!placed && !s_live[c][k]) begin
                    s_live[c][k] = 1'b1; s_age[c][k] = 0; s_dst[c][k] = id_wr_dst; placed = 1'b1;
                end
            end
        end
        if (m_mode[c] == 0) begin
            if (id_valid && id_halt && !st && !ex_redirect) begin m_mode[c] = 1; m_left[c] = 3; end
        end else begin
            if (ex_redirect) begin m_mode[c] = 0; m_left[c] = 0; end
            else if (m_left[c] == 1) m_mode[c] = 2;
            else m_left[c]--;
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_left[c] = 0;
            for (int k = 0; k < 8; k++) s_live[c][k] = 1'b0;
        end
    endtask

    function automatic logic [7:0] obs_a();
        return {1'b0, halted_a, ifid_flush_a, idex_bubble_a, ifid_stall_a, pc_stall_a, state_a};
    endfunction

    function automatic logic [7:0] obs_b();
        return {1'b0, halted_b, ifid_flush_b, idex_bubble_b, ifid_stall_b, pc_stall_b, state_b};
    endfunction

    task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                          input bit we, input int dst, input bit hlt, input bit rd);
        id_valid = v; id_rs = 3'(rs); id_rs_used = rsu; id_rt = 3'(rt); id_rt_used = rtu;
        id_wr_en = we; id_wr_dst = 3'(dst); id_halt = hlt; ex_redirect = rd;
    endtask

    // Called at a negedge with inputs applied; checks, then advances one clock.
    task automatic step(input string tag);
        #1;
        chk({tag, "_nb"}, obs_a(), m_out(0));
        chk({tag, "_wb"}, obs_b(), m_out(1));
        m_advance(0);
        m_advance(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_nb"}, obs_a(), 8'h00);
        chk({tag, "_wb"}, obs_b(), 8'h00);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int na, nb;

    initial begin
        m_reset();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        @(negedge clk);
        do_reset("reset");
        step("reset_first");

        // ADD r3 then a reader of r3: 3 stall cycles without bypass, 2 with.
        set_in(1, 5, 0, 0, 0, 1, 3, 0, 0);
        step("add_r3");
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
        na = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            na += int'(pc_stall_a);
            nb += int'(pc_stall_b);
            step("raw_r3");
        end
        chk("stall_cycles_nb", 8'(na), 8'd3);
        chk("stall_cycles_wb", 8'(nb), 8'd2);

        // Redirect coinciding with a stalled reader.
        set_in(1, 1, 0, 0, 0, 1, 3, 0, 0);
        step("add_r3b");
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 1);
        step("redir_over_stall");
        set_in(0, 3, 1, 0, 0, 0, 0, 0, 0);
        step("after_redir");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("idle");

        // HALT with no hazard: three DRAIN cycles then HALTED for good.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("halt");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("drain");
        for (int i = 0; i < 6; i++) begin
            set_in(1, i, 1, i + 1, 1, 1, i, i % 2, (i % 3) == 0);
            step("halted_hold");
        end
        #1;
        chk("halted_final", {5'b0, halted_a, state_a}, 8'b0000_0110);
        do_reset("reset2");

        // HALT cancelled by a redirect on the second DRAIN cycle.
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("halt2");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain1");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("drain_redir");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("resume");

        // Asynchronous reset between edges during DRAIN.
        set_in(1, 2, 0, 0, 0, 1, 3, 0, 0);
        step("add_before_halt");
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("halt3");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drain_a");
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_nb", obs_a(), 8'h00);
        chk("async_rst_wb", obs_b(), 8'h00);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_in(1, 3, 1, 3, 1, 0, 0, 0, 0);
        step("post_rst_reader");

        // Randomized traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            if ((m_mode[0] == 2 && m_mode[1] == 2) || $urandom_range(0, 199) == 0) begin
                do_reset("rand_rst");
            end else begin
                set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3), $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
                step("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
